byte_stream_decoder: RTL and testbench
======================================

// Module: byte_stream_decoder
// PURPOSE
//  Streaming ByteDecode_ELL stage. Consumes one packed polynomial as a little-endian byte stream.
//  Emits NUM_COEFFS ELL-bit coefficients in index order over a valid/ready handshake.
//  Sits between the byte source (ek/ct/sk buffer) and the NTT/poly RAM writer.
//  Flags coefficients >= Q for the ek modulus check.
// PARAMETERS
//  ELL         12    coefficient width in bits; legal values 1,4,5,10,11,12
//  NUM_COEFFS  256   coefficients per polynomial
//  Q           3329  modulus for the range check; applies only when ELL==12
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     synchronous reset, active-low
//  flush      in   1     synchronous abort of the current polynomial; same effect as reset
//  in_valid   in   1     in_byte valid
//  in_ready   out  1     decoder accepts in_byte this cycle
//  in_byte    in   8     next packed byte; byte 0 of the polynomial comes first
//  out_valid  out  1     out_coeff valid
//  out_ready  in   1     consumer takes out_coeff this cycle
//  out_coeff  out  ELL   decoded coefficient, raw and not reduced
//  out_index  out  8     index of out_coeff, 0..NUM_COEFFS-1
//  out_last   out  1     out_coeff is index NUM_COEFFS-1
//  out_range  out  1     out_coeff >= Q (ELL==12 only, else 0)
//  range_err  out  1     sticky OR of out_range over handshaked coeffs of the current polynomial
//  poly_done  out  1     one-cycle pulse after the last coefficient handshake
// BEHAVIOUR
//  Reset (rst==0 at a clk edge), and flush==1, both clear:
//   - in_ready=0, out_valid=0, out_coeff=0, out_index=0, out_last=0, out_range=0
//   - range_err=0, poly_done=0
//   - bit accumulator, byte counter and coefficient counter
//   - FSM returns to IDLE
//  Any partial polynomial is discarded. Reset takes priority over flush.
//  Bit accumulator: ACC_W = ELL+7 bits, with bit count bcnt.
//   - Byte accept: bits are placed at positions [bcnt+7:bcnt]; bcnt += 8.
//   - Emit: bits [ELL-1:0] load the output register; accumulator shifts right by ELL; bcnt -= ELL.
//   - Accept and emit in the same cycle: bcnt' = bcnt + 8 - ELL.
//  in_ready = (state==RUN) && (bcnt <= ELL-1) && (bytes_in < 32*ELL).
//   - Registered, with no combinational path from out_ready.
//  Emit when bcnt >= ELL && (!out_valid || out_ready): output register reloads.
//   - Zero bubbles under continuous out_ready.
//  Latency: the byte completing a coefficient is accepted at edge t; out_valid=1 after edge t+1.
//  out_* hold stable while out_valid && !out_ready.
//  Coefficient i = bits [ELL*i+ELL-1 : ELL*i] of the concatenated little-endian stream (FIPS 203 ByteDecode).
//  out_range = (ELL==12) && (coeff >= Q), computed at load. range_err sets on handshake of a coeff with out_range=1.
//  FSM:
//   - IDLE: enter RUN at the next edge (after reset, flush or DONE).
//   - RUN -> DONE on handshake with out_last=1.
//   - DONE: poly_done=1 for exactly one cycle; range_err stays valid this cycle. Clears counters and range_err -> RUN.
//  Polynomial length is always 32*ELL bytes, so bcnt==0 at out_last. Extra bytes are refused via in_ready.
//  in_valid may drop mid-polynomial; state holds indefinitely.
//  Counters: bytes_in is 9 bits and saturates at 32*ELL. coeff_idx is 8 bits and never wraps inside a polynomial.
// STRUCTURE
//  kyber_pkg holds:
//   - KYBER_Q=3329 and KYBER_N=256
//   - typedef coeff12_t = logic [11:0]
//   - enum dec_state_e {IDLE, RUN, DONE}
//  Single module, no sub-modules. The accumulator/output register is inline (~200 lines).
//  Later, top_decode instantiates it behind a byte ROM in place of the combinational decode.
// TESTING
//  1) ELL=12, bytes 49 8B 0B FF FE CE B3 C5 6C E7 1E 8B A4 6F 61 EF 07 CD 2A CD 46 16 58 BE CA AE 59 A2 78 50 A1 A4, rest 00, out_ready=1
//     -> coeffs 2889,184,3839,3311,1459,1740,3815,2225,4004,1558,2031,3280,3370,1132,2070,3045,3786,1434,2210,1287,1185,10, then 0 x234.
//     -> range_err=1 at poly_done; poly_done fires once, the cycle after index 255.
//  2) Same stream, out_ready random 30%, in_valid random 50%
//     -> identical coefficient sequence; out_* stable while stalled; no byte is lost or duplicated.
//  3) ELL=12, stream of 384 x 00
//     -> 256 zeros; out_range never 1; range_err=0; in_ready=0 after byte 383 until the next RUN.
//  4) Assert rst=0 after 100 bytes; restart with the test-1 stream
//     -> all outputs 0 during reset; first coeff after restart = 2889, index 0.
//  5) Assert flush at coefficient 50, then send a full polynomial
//     -> next out_index starts at 0; range_err cleared; exactly 256 coefficients follow.
//  6) ELL=1, bytes A5 then 31 x 00
//     -> coeffs 1,0,1,0,0,1,0,1 then 248 zeros; back-to-back with continuous out_ready.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient type and decoder FSM states.
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;

    typedef logic [11:0] coeff12_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dec_state_e;

    // True when a 12-bit coefficient is not a canonical residue mod q.
    function automatic logic coeff_ge_q(input coeff12_t c, input int unsigned q);
        return ({20'd0, c} >= q);
    endfunction

endpackage

// File: rtl/byte_stream_decoder.sv
// Streaming ByteDecode_ELL: unpacks a little-endian byte stream into ELL-bit
// coefficients, one polynomial of 32*ELL bytes at a time, with valid/ready on
// both sides and a modulus range flag for 12-bit coefficients.
module byte_stream_decoder
    import kyber_pkg::*;
#(
    parameter int          ELL        = 12,
    parameter int          NUM_COEFFS = KYBER_N,
    parameter int unsigned Q          = KYBER_Q
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     in_byte,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [ELL-1:0] out_coeff,
    output logic [7:0]     out_index,
    output logic           out_last,
    output logic           out_range,
    output logic           range_err,
    output logic           poly_done
);

    // The accumulator never holds more than ELL-1 leftover bits plus one byte.
    localparam int                ACC_W     = ELL + 7;
    localparam int                BCNT_W    = $clog2(ACC_W + 1);
    localparam logic [BCNT_W-1:0] ELL_B     = BCNT_W'(ELL);
    localparam logic [BCNT_W-1:0] BYTE_B    = BCNT_W'(8);
    localparam logic [8:0]        BYTES_MAX = 9'(32 * ELL);
    localparam logic [7:0]        LAST_IDX  = 8'(NUM_COEFFS - 1);

    dec_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [8:0]        bytes_in_q, bytes_in_d;
    logic [7:0]        coeff_idx_q, coeff_idx_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [ELL-1:0]    out_coeff_q, out_coeff_d;
    logic [7:0]        out_index_q, out_index_d;
    logic              out_last_q, out_last_d;
    logic              out_range_q, out_range_d;
    logic              range_err_q, range_err_d;
    logic              poly_done_q, poly_done_d;

    logic              accept_s;
    logic              out_hs_s;
    logic              emit_s;
    coeff12_t          coeff_ext_s;

    assign accept_s    = in_valid && in_ready_q;
    assign out_hs_s    = out_valid_q && out_ready;
    // The output register reloads whenever it is empty or being drained this cycle.
    assign emit_s      = (state_q == RUN) && (bcnt_q >= ELL_B) && (!out_valid_q || out_ready);
    assign coeff_ext_s = coeff12_t'(acc_q[ELL-1:0]);

    // Next-state logic: accumulator, counters, output register and FSM.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        bcnt_d      = bcnt_q;
        bytes_in_d  = bytes_in_q;
        coeff_idx_d = coeff_idx_q;
        out_valid_d = out_valid_q;
        out_coeff_d = out_coeff_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        out_range_d = out_range_q;
        range_err_d = range_err_q;
        poly_done_d = 1'b0;

        if (out_hs_s) begin
            out_valid_d = 1'b0;
            range_err_d = range_err_q | out_range_q;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (emit_s) begin
            acc_d       = acc_q >> ELL;
            bcnt_d      = bcnt_q - ELL_B;
            out_valid_d = 1'b1;
            out_coeff_d = acc_q[ELL-1:0];
            out_index_d = coeff_idx_q;
            out_last_d  = (coeff_idx_q == LAST_IDX);
            out_range_d = (ELL == 12) && coeff_ge_q(coeff_ext_s, Q);
            if (coeff_idx_q != LAST_IDX) begin
                coeff_idx_d = coeff_idx_q + 8'd1;
            end else begin
                coeff_idx_d = coeff_idx_q;
            end
        end else begin
            acc_d  = acc_q;
            bcnt_d = bcnt_q;
        end

        // New byte lands just above the bits still waiting in the accumulator.
        if (accept_s) begin
            acc_d  = acc_d | (ACC_W'(in_byte) << bcnt_d);
            bcnt_d = bcnt_d + BYTE_B;
            if (bytes_in_q != BYTES_MAX) begin
                bytes_in_d = bytes_in_q + 9'd1;
            end else begin
                bytes_in_d = bytes_in_q;
            end
        end else begin
            bytes_in_d = bytes_in_q;
        end

        case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                if (out_hs_s && out_last_q) begin
                    state_d     = DONE;
                    poly_done_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d     = RUN;
                acc_d       = '0;
                bcnt_d      = '0;
                bytes_in_d  = 9'd0;
                coeff_idx_d = 8'd0;
                range_err_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Computed from next-state values so the registered in_ready matches its
        // definition on the current state without a path from out_ready.
        in_ready_d = (state_d == RUN) && (bcnt_d < ELL_B) && (bytes_in_d < BYTES_MAX);
    end

    // State register with synchronous active-low reset; flush acts identically.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            bcnt_q      <= '0;
            bytes_in_q  <= 9'd0;
            coeff_idx_q <= 8'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_coeff_q <= '0;
            out_index_q <= 8'd0;
            out_last_q  <= 1'b0;
            out_range_q <= 1'b0;
            range_err_q <= 1'b0;
            poly_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            bcnt_q      <= bcnt_d;
            bytes_in_q  <= bytes_in_d;
            coeff_idx_q <= coeff_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_coeff_q <= out_coeff_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            out_range_q <= out_range_d;
            range_err_q <= range_err_d;
            poly_done_q <= poly_done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_coeff = out_coeff_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign out_range = out_range_q;
    assign range_err = range_err_q;
    assign poly_done = poly_done_q;

endmodule

// File: tb/tb_byte_stream_decoder.sv
// Directed bench for byte_stream_decoder: 12-bit and 1-bit instances, hand-computed vectors.
module tb_byte_stream_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush, in_valid, out_ready, sel;
    logic [7:0] in_byte;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_last, a_out_range, a_range_err, a_poly_done;
    logic [11:0] a_out_coeff;
    logic [7:0]  a_out_index;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_last, b_out_range, b_range_err, b_poly_done;
    logic [0:0]  b_out_coeff;
    logic [7:0]  b_out_index;

    logic        m_in_ready, m_out_valid, m_out_last, m_out_range, m_range_err, m_poly_done;
    logic [11:0] m_out_coeff;
    logic [7:0]  m_out_index;

    assign a_in_valid  = in_valid && !sel;
    assign b_in_valid  = in_valid && sel;
    assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign m_out_valid = sel ? b_out_valid : a_out_valid;
    assign m_out_coeff = sel ? {11'd0, b_out_coeff} : a_out_coeff;
    assign m_out_index = sel ? b_out_index : a_out_index;
    assign m_out_last  = sel ? b_out_last  : a_out_last;
    assign m_out_range = sel ? b_out_range : a_out_range;
    assign m_range_err = sel ? b_range_err : a_range_err;
    assign m_poly_done = sel ? b_poly_done : a_poly_done;

    byte_stream_decoder #(.ELL(12)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_byte(in_byte),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_coeff(a_out_coeff),
        .out_index(a_out_index), .out_last(a_out_last), .out_range(a_out_range),
        .range_err(a_range_err), .poly_done(a_poly_done)
    );

    byte_stream_decoder #(.ELL(1)) dut_ell1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_byte(in_byte),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_coeff(b_out_coeff),
        .out_index(b_out_index), .out_last(b_out_last), .out_range(b_out_range),
        .range_err(b_range_err), .poly_done(b_poly_done)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] stream  [0:383];
    int         exp_arr [0:255];

    logic [7:0] t1_bytes [0:31] = '{8'h49, 8'h8B, 8'h0B, 8'hFF, 8'hFE, 8'hCE, 8'hB3, 8'hC5,
                                    8'h6C, 8'hE7, 8'h1E, 8'h8B, 8'hA4, 8'h6F, 8'h61, 8'hEF,
                                    8'h07, 8'hCD, 8'h2A, 8'hCD, 8'h46, 8'h16, 8'h58, 8'hBE,
                                    8'hCA, 8'hAE, 8'h59, 8'hA2, 8'h78, 8'h50, 8'hA1, 8'hA4};
    int t1_exp [0:21] = '{2889, 184, 3839, 3311, 1459, 1740, 3815, 2225, 4004, 1558, 2031,
                          3280, 3370, 1132, 2070, 3045, 3786, 1434, 2210, 1287, 1185, 10};
    int t6_exp [0:7]  = '{1, 0, 1, 0, 0, 1, 0, 1};

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input int got, input int expv);
        n_assert++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_in_ready"},  int'(a_in_ready),  0);
        check_val({tag, "_out_valid"}, int'(a_out_valid), 0);
        check_val({tag, "_out_coeff"}, int'(a_out_coeff), 0);
        check_val({tag, "_out_index"}, int'(a_out_index), 0);
        check_val({tag, "_out_last"},  int'(a_out_last),  0);
        check_val({tag, "_out_range"}, int'(a_out_range), 0);
        check_val({tag, "_range_err"}, int'(a_range_err), 0);
        check_val({tag, "_poly_done"}, int'(a_poly_done), 0);
    endtask

    task automatic load_clear();
        for (int i = 0; i < 384; i++) stream[i] = 8'h00;
        for (int i = 0; i < 256; i++) exp_arr[i] = 0;
    endtask

    task automatic load_t1();
        load_clear();
        for (int i = 0; i < 32; i++) stream[i] = t1_bytes[i];
        for (int i = 0; i < 22; i++) exp_arr[i] = t1_exp[i];
    endtask

    task automatic load_t6();
        load_clear();
        stream[0] = 8'hA5;
        for (int i = 0; i < 8; i++) exp_arr[i] = t6_exp[i];
    endtask

    // Feeds one polynomial and checks every handshaked coefficient; optional early stop.
    task automatic run_poly(input int n_bytes, input int p_valid, input int p_ready,
                            input int stop_rx, input int stop_tx, input int exp_rerr);
        int          tx, rx, cyc;
        logic        hold_v, last_hs, rdy_late, finished;
        logic [11:0] hold_c;
        logic [7:0]  hold_i;
        tx = 0; rx = 0; cyc = 0;
        hold_v = 1'b0; last_hs = 1'b0; rdy_late = 1'b0; finished = 1'b0;
        hold_c = 12'd0; hold_i = 8'd0;
        while (!finished && cyc < 20000) begin
            @(posedge clk);
            #1;
            in_valid  = (tx < n_bytes) && ($urandom_range(99, 0) < p_valid);
            in_byte   = (tx < n_bytes) ? stream[tx] : 8'h00;
            out_ready = ($urandom_range(99, 0) < p_ready);
            @(negedge clk);
            cyc++;
            if (last_hs) begin
                check_val("poly_done",     int'(m_poly_done), 1);
                check_val("range_err",     int'(m_range_err), exp_rerr);
                check_val("in_ready_done", int'(m_in_ready),  0);
                check_val("coeff_count",   rx, 256);
                check_val("ready_late",    int'(rdy_late), 0);
                finished = 1'b1;
            end else begin
                if (m_poly_done) check_val("poly_done_early", int'(m_poly_done), 0);
                if (hold_v) begin
                    check_val("stall_valid", int'(m_out_valid), 1);
                    check_val("stall_coeff", int'(m_out_coeff), int'(hold_c));
                    check_val("stall_index", int'(m_out_index), int'(hold_i));
                end
                if (m_in_ready && tx >= n_bytes) rdy_late = 1'b1;
                else if (in_valid && m_in_ready) tx++;
                if (m_out_valid && out_ready) begin
                    check_val("coeff", int'(m_out_coeff), exp_arr[rx % 256]);
                    check_val("index", int'(m_out_index), rx % 256);
                    check_val("last",  int'(m_out_last),  (rx == 255) ? 1 : 0);
                    check_val("range", int'(m_out_range),
                              (!sel && exp_arr[rx % 256] >= 3329) ? 1 : 0);
                    last_hs = (rx == 255);
                    rx++;
                end
                hold_v = m_out_valid && !out_ready;
                hold_c = m_out_coeff;
                hold_i = m_out_index;
                if (rx == stop_rx || tx == stop_tx) finished = 1'b1;
            end
        end
        if (!finished) check_val("timeout", cyc, 0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0; sel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        check_val("reset_b_in_ready",  int'(b_in_ready),  0);
        check_val("reset_b_out_valid", int'(b_out_valid), 0);
        rst = 1'b1;

        // Known stream, continuous flow
        load_t1();
        run_poly(384, 100, 100, -1, -1, 1);
        // Same stream with random back-pressure and gaps
        run_poly(384, 50, 30, -1, -1, 1);
        // All-zero polynomial
        load_clear();
        run_poly(384, 100, 100, -1, -1, 0);

        // Reset after 100 bytes, then restart
        load_t1();
        run_poly(384, 100, 100, -1, 100, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("rst_mid");
        rst = 1'b1;
        run_poly(384, 100, 100, -1, -1, 1);

        // Flush at coefficient 50, then a full polynomial
        run_poly(384, 100, 100, 50, -1, 0);
        in_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("flush");
        flush = 1'b0;
        run_poly(384, 100, 100, -1, -1, 1);

        // One-bit coefficients
        sel = 1'b1;
        load_t6();
        run_poly(32, 100, 100, -1, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
